// File: rtl/elelock_pkg.sv
// Shared types and constants for the electronic keypad lock.
// Holds the lock state encoding, the blank-digit value and the keypad decode helper.
package elelock_pkg;

  localparam int DIGIT_W = 4;
  localparam logic [DIGIT_W-1:0] BLANK = 4'hF;

  typedef enum logic [1:0] {
    ST_OPEN    = 2'd0,
    ST_LOCKED  = 2'd1,
    ST_LOCKOUT = 2'd2
  } state_t;

  // Index of the set key; only meaningful when exactly one key is down.
  function automatic logic [DIGIT_W-1:0] onehotToBcd(input logic [9:0] keys);
    logic [DIGIT_W-1:0] bcd;
    bcd = '0;
    for (int i = 0; i < 10; i++) begin
      if (keys[i]) bcd = DIGIT_W'(i);
    end
    return bcd;
  endfunction

endpackage

// File: rtl/tenkey_enc.sv
// Keypad front end: reports a digit for one cycle when a single key goes down
// from an all-released keypad; held keys and chords are ignored.
module tenkey_enc
  import elelock_pkg::*;
(
  input  logic               ck,
  input  logic               reset,
  input  logic [9:0]         i_tenkey,
  output logic               o_valid,
  output logic [DIGIT_W-1:0] o_digit
);

  logic [9:0] r_prev;
  logic       w_oneHot;

  always_ff @(posedge ck or posedge reset) begin
    if (reset) r_prev <= '0;
    else       r_prev <= i_tenkey;
  end

  assign w_oneHot = (i_tenkey != '0) && ((i_tenkey & (i_tenkey - 10'd1)) == '0);
  assign o_valid  = w_oneHot && (r_prev == '0);
  assign o_digit  = onehotToBcd(i_tenkey);

endmodule

// File: rtl/elelock_n.sv
// Digit-code door lock with sliding-window code matching.
// Define ELELOCK_ALARM_EN to enable failed-attempt counting, LOCKOUT and the alarm output.
module elelock_n
  import elelock_pkg::*;
#(
  parameter int DIGITS      = 4,
  parameter int MAX_FAIL    = 3,
  parameter int LOCKOUT_CYC = 16
) (
  input  logic       ck,
  input  logic       reset,
  input  logic [9:0] tenkey,
  input  logic       close,
  output logic       lock,
  output logic       alarm
);

`ifdef ELELOCK_ALARM_EN
  localparam bit AlarmEn = 1'b1;
`else
  localparam bit AlarmEn = 1'b0;
`endif

  localparam int KW = DIGITS * DIGIT_W;
  localparam int CW = $clog2(DIGITS + 1);
  localparam int FW = $clog2(MAX_FAIL + 1);
  localparam int LW = $clog2(LOCKOUT_CYC + 1);
  localparam logic [KW-1:0] BlankKey   = {DIGITS{BLANK}};
  localparam logic [CW-1:0] DigitsLast = CW'(DIGITS - 1);
  localparam logic [FW-1:0] FailLast   = FW'(MAX_FAIL - 1);
  localparam logic [LW-1:0] LockLoad   = LW'(LOCKOUT_CYC);
  localparam logic [LW-1:0] LockOne    = LW'(1);

  state_t             r_state, w_stateNext;
  logic               r_lock, w_lockNext;
  logic [KW-1:0]      r_key, r_secret, w_keyShift;
  logic [CW-1:0]      r_dcnt;
  logic [FW-1:0]      r_failCnt;
  logic [LW-1:0]      r_lockCnt;
  logic               w_accept, w_match, w_lastDigit, w_failLimit;
  logic [DIGIT_W-1:0] w_digit;
  logic               w_doClose, w_doShift, w_doMatch, w_doFail, w_doCount;
  logic               w_enterLockout, w_exitLockout;

  tenkey_enc u_enc (
    .ck      (ck),
    .reset   (reset),
    .i_tenkey(tenkey),
    .o_valid (w_accept),
    .o_digit (w_digit)
  );

  assign w_keyShift  = {r_key[KW-DIGIT_W-1:0], w_digit};
  assign w_match     = (w_keyShift == r_secret);
  assign w_lastDigit = (r_dcnt == DigitsLast);
  assign w_failLimit = AlarmEn && (r_failCnt == FailLast);

  always_ff @(posedge ck or posedge reset) begin
    if (reset) begin
      r_state <= ST_OPEN;
      r_lock  <= 1'b0;
    end else begin
      r_state <= w_stateNext;
      r_lock  <= w_lockNext;
    end
  end

  always_comb begin
    w_stateNext    = r_state;
    w_doClose      = 1'b0;
    w_doShift      = 1'b0;
    w_doMatch      = 1'b0;
    w_doFail       = 1'b0;
    w_doCount      = 1'b0;
    w_enterLockout = 1'b0;
    w_exitLockout  = 1'b0;
    case (r_state)
      ST_OPEN: begin
        if (close) begin
          w_doClose   = 1'b1;
          w_stateNext = ST_LOCKED;
        end else if (w_accept) begin
          w_doShift = 1'b1;
        end
      end
      ST_LOCKED: begin
        if (w_accept) begin
          w_doShift = 1'b1;
          if (w_match) begin
            w_doMatch   = 1'b1;
            w_stateNext = ST_OPEN;
          end else if (w_lastDigit) begin
            w_doFail = 1'b1;
            if (w_failLimit) begin
              w_enterLockout = 1'b1;
              w_stateNext    = ST_LOCKOUT;
            end
          end else begin
            w_doCount = 1'b1;
          end
        end
      end
      ST_LOCKOUT: begin
        if (r_lockCnt <= LockOne) begin
          w_exitLockout = 1'b1;
          w_stateNext   = ST_LOCKED;
        end
      end
      default: w_stateNext = ST_OPEN;
    endcase
  end

  always_comb begin
    w_lockNext = (w_stateNext != ST_OPEN);
  end

  // The key window is never cleared on a failed attempt so a code can straddle attempts.
  always_ff @(posedge ck or posedge reset) begin
    if (reset) begin
      r_key     <= BlankKey;
      r_secret  <= '0;
      r_dcnt    <= '0;
      r_failCnt <= '0;
      r_lockCnt <= '0;
    end else begin
      if (w_doClose) begin
        r_secret <= r_key;
        r_key    <= BlankKey;
        r_dcnt   <= '0;
      end else if (w_exitLockout) begin
        r_key     <= BlankKey;
        r_dcnt    <= '0;
        r_failCnt <= '0;
      end else begin
        if (w_doShift) r_key <= w_keyShift;
        if (w_doMatch) begin
          r_failCnt <= '0;
          r_dcnt    <= '0;
        end else if (w_doFail) begin
          if (AlarmEn) r_failCnt <= r_failCnt + 1'b1;
          r_dcnt <= '0;
        end else if (w_doCount) begin
          r_dcnt <= r_dcnt + 1'b1;
        end
      end
      if (w_enterLockout)              r_lockCnt <= LockLoad;
      else if (r_state == ST_LOCKOUT)  r_lockCnt <= r_lockCnt - 1'b1;
    end
  end

  assign lock = r_lock;

`ifdef ELELOCK_ALARM_EN
  logic r_alarm;

  always_ff @(posedge ck or posedge reset) begin
    if (reset) r_alarm <= 1'b0;
    else       r_alarm <= (w_stateNext == ST_LOCKOUT);
  end

  assign alarm = r_alarm;
`else
  assign alarm = 1'b0;
`endif

endmodule

// File: tb/tb_elelock_n.sv
// Bench for elelock_n: directed scenarios plus random keypad traffic, all checked
// every cycle against a digit-array model of the lock behaviour.
module tb_elelock_n;

  localparam int DIGITS      = 4;
  localparam int MAX_FAIL    = 3;
  localparam int LOCKOUT_CYC = 16;
  localparam int KW          = DIGITS * 4;

  logic       ck;
  logic       reset;
  logic [9:0] tenkey;
  logic       close;
  logic       lock;
  logic       alarm;

  int nCompared   = 0;
  int nMismatched = 0;
  bit checkEn     = 1'b0;

  // Model: 0 = open, 1 = locked, 2 = lockout; mKey[0] is the newest digit.
  int         mMode;
  int         mKey[DIGITS];
  int         mSecret[DIGITS];
  int         mDigits;
  int         mFails;
  int         mLeft;
  logic [9:0] mPrev;

  elelock_n #(
    .DIGITS     (DIGITS),
    .MAX_FAIL   (MAX_FAIL),
    .LOCKOUT_CYC(LOCKOUT_CYC)
  ) dut (
    .ck    (ck),
    .reset (reset),
    .tenkey(tenkey),
    .close (close),
    .lock  (lock),
    .alarm (alarm)
  );

  initial ck = 1'b0;
  always #5 ck = ~ck;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    nCompared++;
    if (act !== exp) begin
      nMismatched++;
      $display("[TB] FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [KW-1:0] modelKey();
    logic [KW-1:0] k;
    for (int i = 0; i < DIGITS; i++) k[i*4 +: 4] = 4'(mKey[i]);
    return k;
  endfunction

  function automatic logic [KW-1:0] modelSecret();
    logic [KW-1:0] k;
    for (int i = 0; i < DIGITS; i++) k[i*4 +: 4] = 4'(mSecret[i]);
    return k;
  endfunction

  function automatic void modelReset();
    mMode = 0;
    for (int i = 0; i < DIGITS; i++) begin
      mKey[i]    = 15;
      mSecret[i] = 0;
    end
    mDigits = 0;
    mFails  = 0;
    mLeft   = 0;
    mPrev   = '0;
  endfunction

  function automatic void shiftIn(input int d);
    for (int i = DIGITS - 1; i > 0; i--) mKey[i] = mKey[i-1];
    mKey[0] = d;
  endfunction

  function automatic bit keysEqual();
    for (int i = 0; i < DIGITS; i++) if (mKey[i] != mSecret[i]) return 1'b0;
    return 1'b1;
  endfunction

  function automatic void modelStep();
    bit accepted;
    int digit;
    accepted = (mPrev == '0) && ($countones(tenkey) == 1);
    digit = 0;
    for (int i = 0; i < 10; i++) if (tenkey[i]) digit = i;
    mPrev = tenkey;
    case (mMode)
      0: begin
        if (close) begin
          for (int i = 0; i < DIGITS; i++) begin
            mSecret[i] = mKey[i];
            mKey[i]    = 15;
          end
          mDigits = 0;
          mMode   = 1;
        end else if (accepted) begin
          shiftIn(digit);
        end
      end
      1: begin
        if (accepted) begin
          shiftIn(digit);
          if (keysEqual()) begin
            mMode   = 0;
            mFails  = 0;
            mDigits = 0;
          end else begin
            mDigits++;
            if (mDigits == DIGITS) begin
              mDigits = 0;
`ifdef ELELOCK_ALARM_EN
              mFails++;
              if (mFails == MAX_FAIL) begin
                mMode = 2;
                mLeft = LOCKOUT_CYC;
              end
`endif
            end
          end
        end
      end
      default: begin
        mLeft--;
        if (mLeft == 0) begin
          mMode = 1;
          for (int i = 0; i < DIGITS; i++) mKey[i] = 15;
          mFails  = 0;
          mDigits = 0;
        end
      end
    endcase
  endfunction

  always @(posedge ck or posedge reset) begin
    if (reset) modelReset();
    else       modelStep();
  end

  // Outputs only move on the rising edge or reset, so the falling edge is a safe sample point.
  always @(negedge ck) begin
    if (checkEn) begin
      checkOutput("lock",   32'(lock),         32'(mMode != 0));
      checkOutput("alarm",  32'(alarm),        32'(mMode == 2));
      checkOutput("key",    32'(dut.r_key),    32'(modelKey()));
      checkOutput("secret", 32'(dut.r_secret), 32'(modelSecret()));
    end
  end

  task automatic applyStimulus(input logic [9:0] tk, input logic cl, input logic rs);
    @(posedge ck);
    #1;
    tenkey = tk;
    close  = cl;
    reset  = rs;
  endtask

  task automatic pressDigit(input int d);
    applyStimulus(10'(1) << d, 1'b0, 1'b0);
    applyStimulus(10'd0, 1'b0, 1'b0);
  endtask

  task automatic applyReset();
    applyStimulus(10'd0, 1'b0, 1'b1);
    applyStimulus(10'd0, 1'b0, 1'b1);
    applyStimulus(10'd0, 1'b0, 1'b0);
  endtask

  task automatic closeDoor();
    applyStimulus(10'd0, 1'b1, 1'b0);
    applyStimulus(10'd0, 1'b0, 1'b0);
  endtask

  initial begin
    int wrongCount;
    tenkey = '0;
    close  = 1'b0;
    reset  = 1'b1;
    repeat (3) @(negedge ck);
    checkEn = 1'b1;
    checkOutput("reset_lock",   32'(lock),         32'd0);
    checkOutput("reset_alarm",  32'(alarm),        32'd0);
    checkOutput("reset_key",    32'(dut.r_key),    32'h0000FFFF);
    checkOutput("reset_secret", 32'(dut.r_secret), 32'h0);
    applyStimulus(10'd0, 1'b0, 1'b0);

    // Set a code of 1234 and close.
    pressDigit(1); pressDigit(2); pressDigit(3); pressDigit(4);
    checkOutput("open_key_1234", 32'(dut.r_key), 32'h1234);
    closeDoor();
    checkOutput("close_lock",   32'(lock),         32'd1);
    checkOutput("close_key",    32'(dut.r_key),    32'hFFFF);
    checkOutput("close_secret", 32'(dut.r_secret), 32'h1234);

    // One wrong attempt, then the code completes across the window.
    pressDigit(5); pressDigit(1); pressDigit(2); pressDigit(3);
    checkOutput("wrong_lock", 32'(lock),      32'd1);
    checkOutput("wrong_key",  32'(dut.r_key), 32'h5123);
`ifdef ELELOCK_ALARM_EN
    checkOutput("wrong_failcnt", 32'(dut.r_failCnt), 32'd1);
    checkOutput("model_fails",   32'(mFails),        32'd1);
`endif
    pressDigit(4);
    checkOutput("slide_unlock", 32'(lock),      32'd0);
    checkOutput("slide_key",    32'(dut.r_key), 32'h1234);

`ifdef ELELOCK_ALARM_EN
    // Three wrong attempts trigger lockout; presses and closes are ignored meanwhile.
    closeDoor();
    for (int i = 0; i < 3 * DIGITS; i++) pressDigit(7);
    checkOutput("lockout_alarm", 32'(alarm), 32'd1);
    checkOutput("lockout_lock",  32'(lock),  32'd1);
    for (int k = 1; k < LOCKOUT_CYC; k++) begin
      applyStimulus((k % 2 == 1) ? 10'(1) << 1 : 10'd0, k % 2 == 1, 1'b0);
      checkOutput("lockout_hold", 32'(alarm), 32'd1);
    end
    applyStimulus(10'd0, 1'b0, 1'b0);
    checkOutput("lockout_end_alarm", 32'(alarm),      32'd0);
    checkOutput("lockout_end_lock",  32'(lock),       32'd1);
    checkOutput("lockout_end_key",   32'(dut.r_key),  32'hFFFF);
    pressDigit(1); pressDigit(2); pressDigit(3); pressDigit(4);
    checkOutput("after_lockout_unlock", 32'(lock), 32'd0);
    wrongCount = 3 * DIGITS;
`else
    wrongCount = 2;
`endif

    // Reset in the middle of an operation takes effect without a clock edge.
    closeDoor();
    for (int i = 0; i < wrongCount; i++) pressDigit(7);
    checkOutput("pre_reset_lock", 32'(lock), 32'd1);
    applyStimulus(10'd0, 1'b0, 1'b0);
    reset = 1'b1;
    #2;
    checkOutput("async_reset_lock",  32'(lock),      32'd0);
    checkOutput("async_reset_alarm", 32'(alarm),     32'd0);
    checkOutput("async_reset_key",   32'(dut.r_key), 32'hFFFF);
    applyStimulus(10'd0, 1'b0, 1'b1);
    applyStimulus(10'd0, 1'b0, 1'b0);

    // Single-digit code sits in a blank-padded window.
    pressDigit(9);
    closeDoor();
    checkOutput("nine_secret", 32'(dut.r_secret), 32'hFFF9);
    checkOutput("nine_lock",   32'(lock),         32'd1);
    pressDigit(9);
    checkOutput("nine_unlock", 32'(lock), 32'd0);

    // A held key counts once and a chord does not count.
    applyReset();
    repeat (8) applyStimulus(10'(1) << 3, 1'b0, 1'b0);
    applyStimulus(10'b00_0010_0100, 1'b0, 1'b0);
    applyStimulus(10'd0, 1'b0, 1'b0);
    applyStimulus(10'd0, 1'b0, 1'b0);
    checkOutput("held_chord_key", 32'(dut.r_key), 32'hFFF3);

    // Random keypad traffic biased toward a small digit set so matches happen.
    for (int c = 0; c < 3000; c++) begin
      int r, a, b;
      logic [9:0] tk;
      r  = int'($urandom_range(0, 99));
      a  = (int'($urandom_range(0, 9)) < 8) ? int'($urandom_range(1, 2)) : int'($urandom_range(0, 9));
      if (r < 45) begin
        tk = '0;
      end else if (r < 85) begin
        tk = 10'(1) << a;
      end else if (r < 95) begin
        b  = (a + 1 + int'($urandom_range(0, 8))) % 10;
        tk = (10'(1) << a) | (10'(1) << b);
      end else begin
        tk = 10'h3FF;
      end
      applyStimulus(tk, $urandom_range(0, 99) < 8, $urandom_range(0, 999) < 4);
    end
    applyReset();
    repeat (3) applyStimulus(10'd0, 1'b0, 1'b0);
    @(negedge ck);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
    $finish;
  end

endmodule
